eco32f_div_ctrl: RTL

- Iterative divide/remainder sequencer for the execute stage.
- Accepts div/rem ops already decoded into EX (ex_op_div, ex_op_rem, ex_signed_div).
- Runs a 32-step radix-2 restoring division on a shared remainder/quotient datapath.
- Stalls the pipeline until the result is ready, and holds the result until the instruction leaves EX.

---
 rtl/eco32f_div_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/eco32f_div_ctrl.sv
// eco32f_div_ctrl: iterative radix-2 restoring divide/remainder sequencer for EX.
// Stalls the pipeline while dividing and holds the result until EX advances.
// Optional macro ECO32F_DIV_EARLY_OUT_EN: skip the iteration when |a| < |b|.
module eco32f_div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_op_div,
  input  logic             ex_op_rem,
  input  logic             ex_signed_div,
  input  logic             ex_flush,
  input  logic             ex_advance,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  output logic             div_stall,
  output logic             div_valid,
  output logic [WIDTH-1:0] div_result,
  output logic             div_exc_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             op_rem_q, op_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             exc_q, exc_d;
  logic             stall_c;

  logic             go_c;
  logic             b_zero_c;
  logic             early_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

  assign go_c     = (ex_op_div | ex_op_rem) & ~ex_flush;
  assign b_zero_c = (ex_b == '0);
  assign mag_a_c  = (ex_signed_div & ex_a[WIDTH-1]) ? -ex_a : ex_a;
  assign mag_b_c  = (ex_signed_div & ex_b[WIDTH-1]) ? -ex_b : ex_b;

  // Trial subtraction one bit wider than the operands; MSB is the borrow.
  assign trial_c   = {1'b0, rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} - {1'b0, dvs_q};
  assign quo_fix_c = neg_quo_q ? -dvd_q : dvd_q;
  assign rem_fix_c = neg_rem_q ? -rem_q : rem_q;

`ifdef ECO32F_DIV_EARLY_OUT_EN
  assign early_c = (mag_a_c < mag_b_c);
`else
  assign early_c = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      op_rem_q  <= op_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      exc_q     <= exc_d;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (go_c) begin
          if (b_zero_c)     state_d = S_DONE;
          else if (early_c) state_d = S_FIX;
          else              state_d = S_CALC;
        end
      end
      S_CALC: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (ex_advance) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ex_flush) state_d = S_IDLE;
  end

  // Datapath updates, result/flag registers and the stall request
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    op_rem_d  = op_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    valid_d   = valid_q;
    exc_d     = exc_q;
    stall_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_c = go_c;
        if (go_c) begin
          valid_d = 1'b0;
          exc_d   = 1'b0;
          if (b_zero_c) begin
            valid_d  = 1'b1;
            exc_d    = 1'b1;
            result_d = '0;
          end else begin
            op_rem_d  = ex_op_rem;
            neg_quo_d = ex_signed_div & (ex_a[WIDTH-1] ^ ex_b[WIDTH-1]);
            neg_rem_d = ex_signed_div & ex_a[WIDTH-1];
            dvs_d     = mag_b_c;
            if (early_c) begin
              dvd_d = '0;
              rem_d = mag_a_c;
              cnt_d = '0;
            end else begin
              dvd_d = mag_a_c;
              rem_d = '0;
              cnt_d = CW'(WIDTH - 1);
            end
          end
        end
      end
      S_CALC: begin
        stall_c = 1'b1;
        if (!trial_c[WIDTH]) begin
          rem_d = trial_c[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      S_FIX: begin
        stall_c  = 1'b1;
        result_d = op_rem_q ? rem_fix_c : quo_fix_c;
        valid_d  = 1'b1;
        exc_d    = 1'b0;
      end
      S_DONE: begin
        if (ex_advance) begin
          valid_d = 1'b0;
          exc_d   = 1'b0;
        end
      end
      default: ;
    endcase
    if (ex_flush) begin
      valid_d  = 1'b0;
      exc_d    = 1'b0;
      result_d = '0;
    end
  end

  assign div_stall    = rst & stall_c;
  assign div_valid    = valid_q;
  assign div_result   = result_q;
  assign div_exc_zero = exc_q;

endmodule
